// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler: shares the single VGA pixel-write port between N sprite drawers, one erase/draw pass at a time.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   frame_tick            once-per-frame pulse; starts a sweep over all slots when idle
//   slot_enable[N]        per-slot visibility, latched on an accepted frame_tick
//   slot_colour[3N]       per-slot draw colour
//   px_valid/px_x/px_y    per-drawer pixel streams
//   slot_done[N]          per-drawer pass-complete level
//   start[N]              one-hot restart pulse to the active drawer
//   erase                 high through the erase pass
//   plot/plot_x/plot_y/colour  registered pixel write to the VGA adapter
//   busy                  sweep in progress
//   frame_overrun         pulse when a frame_tick is dropped because the sweep is still running
//   timeout_err           sticky flag for any pass that never reported done
module sprite_frame_scheduler #(
    parameter int N_SPRITES = 8,
    parameter int TIMEOUT = 63,
    parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic [N_SPRITES-1:0]     slot_enable,
    input  logic [3*N_SPRITES-1:0]   slot_colour,
    input  logic [N_SPRITES-1:0]     px_valid,
    input  logic [8*N_SPRITES-1:0]   px_x,
    input  logic [7*N_SPRITES-1:0]   px_y,
    input  logic [N_SPRITES-1:0]     slot_done,
    output logic [N_SPRITES-1:0]     start,
    output logic                     erase,
    output logic                     plot,
    output logic [7:0]               plot_x,
    output logic [6:0]               plot_y,
    output logic [2:0]               colour,
    output logic                     busy,
    output logic                     frame_overrun,
    output logic                     timeout_err
);
    localparam int SW = N_SPRITES > 1 ? $clog2(N_SPRITES) : 1;
    localparam logic [SW-1:0] LAST = SW'(N_SPRITES - 1);
    typedef enum logic [2:0] {IDLE, CHECK, START_E, WAIT_E, START_D, WAIT_D, NEXT} state_t;
    state_t state, state_n;
    logic [SW-1:0] slot;
    logic [N_SPRITES-1:0] cur_en, prev_en;
    logic [7:0] timer;
    logic waiting, timed_out, finished;
    int unsigned idx;
    assign idx = int'(slot);
    assign waiting = state == WAIT_E || state == WAIT_D;
    assign timed_out = timer == 8'(TIMEOUT);
    // timer==0 marks the first wait cycle, where the drawer's done is still stale from its previous pass
    assign finished = (slot_done[slot] && timer != 8'd0) || timed_out;
    assign busy = state != IDLE;
    always_comb begin
        state_n = state;
        start = '0;
        erase = 1'b0;
        case (state)
            IDLE:    state_n = frame_tick ? CHECK : IDLE;
            CHECK:   state_n = prev_en[slot] ? START_E : cur_en[slot] ? START_D : NEXT;
            START_E: begin
                start[slot] = 1'b1;
                erase = 1'b1;
                state_n = WAIT_E;
            end
            WAIT_E:  begin
                erase = 1'b1;
                state_n = !finished ? WAIT_E : cur_en[slot] ? START_D : NEXT;
            end
            START_D: begin
                start[slot] = 1'b1;
                state_n = WAIT_D;
            end
            WAIT_D:  state_n = finished ? NEXT : WAIT_D;
            NEXT:    state_n = slot == LAST ? IDLE : CHECK;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            slot <= '0;
            cur_en <= '0;
            prev_en <= '0;
            timer <= 8'd0;
            plot <= 1'b0;
            plot_x <= 8'd0;
            plot_y <= 7'd0;
            colour <= 3'd0;
            frame_overrun <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && frame_tick) begin
                prev_en <= cur_en;
                cur_en <= slot_enable;
            end
            if (state == NEXT)
                slot <= slot == LAST ? '0 : slot + 1'b1;
            timer <= !waiting ? 8'd0 : timed_out ? timer : timer + 8'd1;
            if (waiting && timed_out)
                timeout_err <= 1'b1;
            plot <= waiting && px_valid[slot];
            if (waiting) begin
                plot_x <= px_x[8*idx +: 8];
                plot_y <= px_y[7*idx +: 7];
                colour <= erase ? ERASE_COLOUR : slot_colour[3*idx +: 3];
            end
            frame_overrun <= frame_tick && state != IDLE;
        end
    end
endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// tb_sprite_frame_scheduler: directed bench with behavioural drawers and per-colour plot accounting.
module tb_sprite_frame_scheduler;
    localparam int N = 8;
    localparam int NPIX = 13;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic [N-1:0] slot_enable = '0;
    logic [3*N-1:0] slot_colour;
    logic [N-1:0] px_valid;
    logic [8*N-1:0] px_x;
    logic [7*N-1:0] px_y;
    logic [N-1:0] slot_done;
    logic [N-1:0] start;
    logic erase, plot, busy, frame_overrun, timeout_err;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] colour;
    int n_chk = 0;
    int n_err = 0;
    always #5 clock = ~clock;
    sprite_frame_scheduler #(.N_SPRITES(N), .TIMEOUT(63), .ERASE_COLOUR(3'b000)) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .slot_enable(slot_enable),
        .slot_colour(slot_colour), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
        .slot_done(slot_done), .start(start), .erase(erase), .plot(plot), .plot_x(plot_x),
        .plot_y(plot_y), .colour(colour), .busy(busy), .frame_overrun(frame_overrun),
        .timeout_err(timeout_err)
    );
    // Drawer model: NPIX pixels after each start; done drops one cycle late (stale) and rises after the last pixel.
    int cnt [N] = '{default: 0};
    logic [N-1:0] clr = '0;
    logic [N-1:0] done_r = '1;
    logic [N-1:0] hang = '0;
    logic [N-1:0] noise = 8'h40;
    assign slot_done = done_r;
    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (start[i]) begin
                cnt[i] <= NPIX;
                clr[i] <= 1'b1;
            end else begin
                if (cnt[i] > 0) cnt[i] <= cnt[i] - 1;
                if (clr[i]) begin
                    done_r[i] <= 1'b0;
                    clr[i] <= 1'b0;
                end
                if (cnt[i] == 1 && !hang[i]) done_r[i] <= 1'b1;
            end
        end
    end
    always_comb begin
        px_valid = '0;
        px_x = '0;
        px_y = '0;
        slot_colour = '0;
        for (int i = 0; i < N; i++) begin
            px_valid[i] = cnt[i] > 0 || noise[i];
            px_x[8*i +: 8] = 8'(20*i + NPIX - cnt[i]);
            px_y[7*i +: 7] = 7'(5 + i);
            slot_colour[3*i +: 3] = 3'(i % 7 + 1);
        end
    end
    // Monotonic activity counters; the stimulus works with deltas against a snapshot.
    int cyc = 0;
    int plots_c [8] = '{default: 0};
    int starts [N] = '{default: 0};
    int st_cyc [N] = '{default: 0};
    int erase_cyc = 0, ovr = 0, sum_x = 0;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (plot === 1'b1) begin
            plots_c[colour] = plots_c[colour] + 1;
            sum_x = sum_x + int'(plot_x);
        end
        if (erase === 1'b1) erase_cyc = erase_cyc + 1;
        if (frame_overrun === 1'b1) ovr = ovr + 1;
        for (int i = 0; i < N; i++)
            if (start[i] === 1'b1) begin
                starts[i] = starts[i] + 1;
                st_cyc[i] = cyc;
            end
    end
    int b_plots [8];
    int b_starts [N];
    int b_erase, b_ovr, b_sumx;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic snap();
        b_plots = plots_c;
        b_starts = starts;
        b_erase = erase_cyc;
        b_ovr = ovr;
        b_sumx = sum_x;
    endtask
    function automatic int dp(input int c);
        return plots_c[c] - b_plots[c];
    endfunction
    function automatic int ds(input int s);
        return starts[s] - b_starts[s];
    endfunction
    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk(tag, 32'(busy), 0);
    endtask
    task automatic send_tick(input logic [N-1:0] en);
        slot_enable = en;
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask
    task automatic frame(input logic [N-1:0] en, input string tag);
        @(negedge clock);
        snap();
        send_tick(en);
        wait_idle(tag);
    endtask
    initial begin
        int hi, pc;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_erase", 32'(erase), 0);
        chk("rst_ovr", 32'(frame_overrun), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        chk("rst_xyc", {13'd0, plot_x, plot_y, colour}, 0);
        reset = 1'b0;
        // 1: first frame, slot0 draw only
        frame(8'h01, "t1_done");
        chk("t1_draw", dp(1), 13);
        chk("t1_erasepx", dp(0), 0);
        chk("t1_noise", dp(7), 0);
        chk("t1_sumx", sum_x - b_sumx, 78);
        chk("t1_y", 32'(plot_y), 5);
        chk("t1_start0", ds(0), 1);
        hi = 0;
        for (int i = 1; i < N; i++) hi += ds(i);
        chk("t1_start_oth", hi, 0);
        chk("t1_erasecyc", erase_cyc - b_erase, 0);
        chk("t1_ovr", ovr - b_ovr, 0);
        // 2: same enables, erase then redraw
        frame(8'h01, "t2_done");
        chk("t2_erasepx", dp(0), 13);
        chk("t2_draw", dp(1), 13);
        chk("t2_start0", ds(0), 2);
        chk("t2_erasecyc", erase_cyc - b_erase, 15);
        chk("t2_sumx", sum_x - b_sumx, 156);
        // 3: slot1 on then off
        frame(8'h03, "t3a_done");
        chk("t3a_s1draw", dp(2), 13);
        chk("t3a_erasepx", dp(0), 13);
        frame(8'h01, "t3b_done");
        chk("t3b_erasepx", dp(0), 26);
        chk("t3b_s0draw", dp(1), 13);
        chk("t3b_s1draw", dp(2), 0);
        chk("t3b_start1", ds(1), 1);
        chk("t3b_start0", ds(0), 2);
        chk("t3b_terr", 32'(timeout_err), 0);
        // 4: drawer2 hangs, pass aborts, slot3 still drawn
        hang[2] = 1'b1;
        frame(8'h0C, "t4_done");
        chk("t4_terr", 32'(timeout_err), 1);
        chk("t4_s2px", dp(3), 13);
        chk("t4_s3px", dp(4), 13);
        chk("t4_erasepx", dp(0), 13);
        chk("t4_start3", ds(3), 1);
        chk("t4_gap", st_cyc[3] - st_cyc[2], 67);
        // 5: tick while busy is dropped
        hang[2] = 1'b0;
        @(negedge clock);
        snap();
        send_tick(8'h0C);
        repeat (5) @(negedge clock);
        chk("t5_busy", 32'(busy), 1);
        send_tick(8'hF0);
        wait_idle("t5_done");
        chk("t5_ovr", ovr - b_ovr, 1);
        chk("t5_s2px", dp(3), 13);
        chk("t5_s3px", dp(4), 13);
        chk("t5_erasepx", dp(0), 26);
        chk("t5_start3", ds(3), 2);
        frame(8'h00, "t5b_done");
        chk("t5b_erasepx", dp(0), 26);
        chk("t5b_draw", dp(3) + dp(4), 0);
        hi = 0;
        for (int i = 4; i < N; i++) hi += ds(i);
        chk("t5b_start_hi", hi, 0);
        chk("t5b_terr_sticky", 32'(timeout_err), 1);
        // 6: reset in the middle of a draw pass
        @(negedge clock);
        snap();
        send_tick(8'h01);
        hi = 0;
        while (plot !== 1'b1 && hi < 50) begin
            @(negedge clock);
            hi++;
        end
        chk("t6_plot_seen", 32'(plot), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_plot", 32'(plot), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_start", 32'(start), 0);
        chk("t6_erase", 32'(erase), 0);
        chk("t6_terr", 32'(timeout_err), 0);
        chk("t6_xyc", {13'd0, plot_x, plot_y, colour}, 0);
        reset = 1'b0;
        pc = plots_c[1];
        repeat (30) @(negedge clock);
        chk("t6_noplot", plots_c[1] - pc, 0);
        chk("t6_idle", 32'(busy), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
